// File: rtl/jtag_ir_ctrl_if.sv
// jtag_ir_ctrl_if: TAP strobes into, and decoded instruction state out of, the IR controller
interface jtag_ir_ctrl_if #(
   parameter int IR_WIDTH = 4
);
   logic                tlr;
   logic                capture_ir;
   logic                shift_ir;
   logic                update_ir;
   logic                tdi;
   logic                ir_tdo;
   logic [IR_WIDTH-1:0] latch_jtag_ir;
   logic [6:0]          select;
   logic                undef_opcode;
   logic                ir_updated;
   modport master (
      output tlr, capture_ir, shift_ir, update_ir, tdi,
      input  ir_tdo, latch_jtag_ir, select, undef_opcode, ir_updated
   );
   modport slave (
      input  tlr, capture_ir, shift_ir, update_ir, tdi,
      output ir_tdo, latch_jtag_ir, select, undef_opcode, ir_updated
   );
endinterface

// File: rtl/jtag_ir_ctrl.sv
// jtag_ir_ctrl: JTAG instruction register (shift + update stages) with registered one-hot decode
module jtag_ir_ctrl #(
   parameter int                  IR_WIDTH        = 4,
   parameter logic [IR_WIDTH-1:0] OPC_IDCODE      = IR_WIDTH'(4'h7),
   parameter logic [IR_WIDTH-1:0] OPC_BYPASS      = '1,
   parameter logic [IR_WIDTH-1:0] OPC_SAMPLE      = IR_WIDTH'(4'h1),
   parameter logic [IR_WIDTH-1:0] OPC_EXTEST      = IR_WIDTH'(4'h2),
   parameter logic [IR_WIDTH-1:0] OPC_INTEST      = IR_WIDTH'(4'h3),
   parameter logic [IR_WIDTH-1:0] OPC_USERCODE    = IR_WIDTH'(4'h8),
   parameter logic [IR_WIDTH-1:0] OPC_RUNBIST     = IR_WIDTH'(4'h4),
   parameter logic [IR_WIDTH-1:0] CAPTURE_VAL     = IR_WIDTH'(2'b01),
   parameter bit                  UNDEF_AS_BYPASS = 1'b1
) (
   input logic           i_tck,
   input logic           i_rst,
   jtag_ir_ctrl_if.slave bus
);
   localparam logic [IR_WIDTH-1:0] OPCS [7] = '{OPC_IDCODE, OPC_BYPASS, OPC_SAMPLE, OPC_EXTEST,
                                                OPC_INTEST, OPC_USERCODE, OPC_RUNBIST};
   localparam logic [6:0] SEL_IDCODE = 7'b0000001;
   localparam logic [6:0] SEL_UNDEF  = UNDEF_AS_BYPASS ? 7'b0000010 : SEL_IDCODE;

   if (IR_WIDTH < 2) begin : g_width_err
      $error("jtag_ir_ctrl: IR_WIDTH must be >= 2");
   end else if (CAPTURE_VAL[1:0] != 2'b01) begin : g_cap_err
      $error("jtag_ir_ctrl: CAPTURE_VAL[1:0] must be 2'b01");
   end
   for (genvar i = 0; i < 7; i++) begin : g_i
      for (genvar j = i + 1; j < 7; j++) begin : g_j
         if (OPCS[i] == OPCS[j]) begin : g_dup
            $error("jtag_ir_ctrl: duplicate opcode values");
         end
      end
   end

   logic [IR_WIDTH-1:0] r_sr;
   logic [IR_WIDTH-1:0] r_latch;
   logic [6:0]          r_sel;
   logic                r_undef;
   logic                r_upd;
   logic [6:0]          w_hit;
   logic [6:0]          w_sel;
   logic                w_undef;

   // decode the shift stage so select/undef land together with the latch on update
   always_comb begin
      w_hit = '0;
      for (int k = 0; k < 7; k++) w_hit[k] = (r_sr == OPCS[k]);
      w_undef = ~|w_hit;
      w_sel   = w_undef ? SEL_UNDEF : w_hit;
   end

   // strobe priority: reset, test-logic-reset, update, capture, shift
   always_ff @(posedge i_tck) begin
      if (i_rst) begin
         r_sr    <= CAPTURE_VAL;
         r_latch <= OPC_IDCODE;
         r_sel   <= SEL_IDCODE;
         r_undef <= 1'b0;
         r_upd   <= 1'b0;
      end else if (bus.tlr) begin
         r_latch <= OPC_IDCODE;
         r_sel   <= SEL_IDCODE;
         r_undef <= 1'b0;
         r_upd   <= r_latch != OPC_IDCODE;
      end else if (bus.update_ir) begin
         r_latch <= r_sr;
         r_sel   <= w_sel;
         r_undef <= w_undef;
         r_upd   <= r_latch != r_sr;
      end else begin
         r_upd <= 1'b0;
         if (bus.capture_ir) r_sr <= CAPTURE_VAL;
         else if (bus.shift_ir) r_sr <= {bus.tdi, r_sr[IR_WIDTH-1:1]};
      end
   end

   assign bus.ir_tdo        = r_sr[0];
   assign bus.latch_jtag_ir = r_latch;
   assign bus.select        = r_sel;
   assign bus.undef_opcode  = r_undef;
   assign bus.ir_updated    = r_upd;
endmodule

// File: tb/tb_jtag_ir_ctrl.sv
// tb_jtag_ir_ctrl: directed checks of the IR controller in three configurations sharing one stimulus
module tb_jtag_ir_ctrl;
   logic tck = 1'b0;
   logic rst, tlr, cap, sh, upd, tdi;
   int   n_total = 0;
   int   n_pass  = 0;

   jtag_ir_ctrl_if #(.IR_WIDTH(4)) ifa ();
   jtag_ir_ctrl_if #(.IR_WIDTH(4)) ifb ();
   jtag_ir_ctrl_if #(.IR_WIDTH(8)) ifc ();

   assign ifa.tlr = tlr;  assign ifa.capture_ir = cap;  assign ifa.shift_ir = sh;
   assign ifa.update_ir = upd;  assign ifa.tdi = tdi;
   assign ifb.tlr = tlr;  assign ifb.capture_ir = cap;  assign ifb.shift_ir = sh;
   assign ifb.update_ir = upd;  assign ifb.tdi = tdi;
   assign ifc.tlr = tlr;  assign ifc.capture_ir = cap;  assign ifc.shift_ir = sh;
   assign ifc.update_ir = upd;  assign ifc.tdi = tdi;

   jtag_ir_ctrl #(.IR_WIDTH(4)) dut_a (.i_tck(tck), .i_rst(rst), .bus(ifa));
   jtag_ir_ctrl #(.IR_WIDTH(4), .UNDEF_AS_BYPASS(1'b0)) dut_b (.i_tck(tck), .i_rst(rst), .bus(ifb));
   jtag_ir_ctrl #(.IR_WIDTH(8)) dut_c (.i_tck(tck), .i_rst(rst), .bus(ifc));

   always #5 tck = ~tck;

   task automatic tick();
      @(posedge tck);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic shift4(input logic [3:0] v, input bit check_tdo, input logic [3:0] exp_tdo);
      cap = 1'b1;
      tick();
      cap = 1'b0;
      sh  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tdi = v[i];
         if (check_tdo) chk($sformatf("tdo_bit%0d", i), 32'(ifa.ir_tdo), 32'(exp_tdo[i]));
         tick();
      end
      sh = 1'b0;
   endtask

   task automatic update();
      upd = 1'b1;
      tick();
      upd = 1'b0;
   endtask

   initial begin
      rst = 1'b1; tlr = 1'b0; cap = 1'b0; sh = 1'b0; upd = 1'b0; tdi = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_latch", 32'(ifa.latch_jtag_ir), 32'h7);
      chk("rst_select", 32'(ifa.select), 32'h01);
      chk("rst_undef", 32'(ifa.undef_opcode), 32'h0);
      chk("rst_updated", 32'(ifa.ir_updated), 32'h0);
      chk("rst_tdo", 32'(ifa.ir_tdo), 32'h1);
      chk("rst_latch_w8", 32'(ifc.latch_jtag_ir), 32'h07);
      // EXTEST: TDO must emit the capture pattern 1,0,0,0
      shift4(4'h2, 1'b1, 4'b0001);
      chk("hold_before_upd", 32'(ifa.latch_jtag_ir), 32'h7);
      update();
      chk("extest_latch", 32'(ifa.latch_jtag_ir), 32'h2);
      chk("extest_select", 32'(ifa.select), 32'h08);
      chk("extest_pulse", 32'(ifa.ir_updated), 32'h1);
      tick();
      chk("extest_pulse_end", 32'(ifa.ir_updated), 32'h0);
      chk("extest_latch_hold", 32'(ifa.latch_jtag_ir), 32'h2);
      // undefined opcode under both policies
      shift4(4'hA, 1'b0, 4'h0);
      update();
      chk("undef_latch", 32'(ifa.latch_jtag_ir), 32'hA);
      chk("undef_sel_bypass", 32'(ifa.select), 32'h02);
      chk("undef_flag", 32'(ifa.undef_opcode), 32'h1);
      chk("undef_sel_idcode", 32'(ifb.select), 32'h01);
      chk("undef_flag_b", 32'(ifb.undef_opcode), 32'h1);
      // shifting alone must not disturb the active instruction
      shift4(4'h4, 1'b0, 4'h0);
      chk("shift_hold_sel", 32'(ifa.select), 32'h02);
      chk("shift_hold_latch", 32'(ifa.latch_jtag_ir), 32'hA);
      update();
      chk("runbist_select", 32'(ifa.select), 32'h40);
      chk("runbist_undef", 32'(ifa.undef_opcode), 32'h0);
      chk("runbist_pulse", 32'(ifa.ir_updated), 32'h1);
      tick();
      update();
      chk("same_opc_no_pulse", 32'(ifa.ir_updated), 32'h0);
      chk("same_opc_select", 32'(ifa.select), 32'h40);
      // TLR from INTEST
      shift4(4'h3, 1'b0, 4'h0);
      update();
      chk("intest_select", 32'(ifa.select), 32'h10);
      tlr = 1'b1;
      tick();
      tlr = 1'b0;
      chk("tlr_latch", 32'(ifa.latch_jtag_ir), 32'h7);
      chk("tlr_select", 32'(ifa.select), 32'h01);
      chk("tlr_pulse", 32'(ifa.ir_updated), 32'h1);
      chk("tlr_sr_kept", 32'(ifa.ir_tdo), 32'h1);
      // reset in the middle of a shift
      shift4(4'h2, 1'b0, 4'h0);
      update();
      chk("pre_abort_latch", 32'(ifa.latch_jtag_ir), 32'h2);
      cap = 1'b1;
      tick();
      cap = 1'b0;
      sh  = 1'b1;
      tdi = 1'b0;
      tick();
      tick();
      chk("mid_shift_tdo", 32'(ifa.ir_tdo), 32'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sh  = 1'b0;
      chk("abort_latch", 32'(ifa.latch_jtag_ir), 32'h7);
      chk("abort_select", 32'(ifa.select), 32'h01);
      chk("abort_tdo", 32'(ifa.ir_tdo), 32'h1);
      chk("abort_updated", 32'(ifa.ir_updated), 32'h0);
      // over-long shift of ones: only the last IR_WIDTH bits remain
      sh  = 1'b1;
      tdi = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      sh = 1'b0;
      update();
      chk("w8_latch", 32'(ifc.latch_jtag_ir), 32'hFF);
      chk("w8_select", 32'(ifc.select), 32'h02);
      chk("w8_undef", 32'(ifc.undef_opcode), 32'h0);
      chk("w8_pulse", 32'(ifc.ir_updated), 32'h1);
      chk("w4_bypass_latch", 32'(ifa.latch_jtag_ir), 32'hF);
      chk("w4_bypass_select", 32'(ifa.select), 32'h02);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/jtag_ir_ctrl.md
Name: jtag_ir_ctrl

Overview:
Parametrised JTAG instruction register with integrated decoder, the successor to the fixed 4-bit combinational instruction decoder. Holds the IR shift stage and the update (latched) stage, and produces registered one-hot instruction selects. It is driven by the TAP controller's state strobes and feeds the data-register mux and the boundary-scan/BIST blocks. The IR width, the opcodes, the capture pattern and the policy for undefined opcodes are all configurable.

Parameters:
IR_WIDTH, 4, instruction register width in bits; must be >= 2 (elaboration error otherwise).
OPC_IDCODE, 4'h7, IDCODE opcode.
OPC_BYPASS, all ones, BYPASS opcode.
OPC_SAMPLE, 4'h1, SAMPLE/PRELOAD opcode.
OPC_EXTEST, 4'h2, EXTEST opcode.
OPC_INTEST, 4'h3, INTEST opcode.
OPC_USERCODE, 4'h8, USERCODE opcode.
OPC_RUNBIST, 4'h4, RUNBIST opcode.
CAPTURE_VAL, {zeros,2'b01}, value loaded into the shift stage on CAPTURE_IR; the two LSBs must be 2'b01.
UNDEF_AS_BYPASS, 1, undefined-opcode policy: 1 selects BYPASS, 0 selects IDCODE.

Ports:
TCK  input  1  test clock; the only clock, rising edge.
RST  input  1  synchronous, active-high reset.
TLR  input  1  TAP in Test-Logic-Reset; level-sensitive.
CAPTURE_IR  input  1  TAP in Capture-IR.
SHIFT_IR  input  1  TAP in Shift-IR.
UPDATE_IR  input  1  TAP in Update-IR.
TDI  input  1  serial data in.
IR_TDO  output  1  serial data out; equals shift-stage bit 0 (combinational from a flop).
LATCH_JTAG_IR  output  IR_WIDTH  current latched instruction.
SELECT  output  7  one-hot select: [0]IDCODE [1]BYPASS [2]SAMPLE [3]EXTEST [4]INTEST [5]USERCODE [6]RUNBIST.
UNDEF_OPCODE  output  1  latched instruction matches no defined opcode.
IR_UPDATED  output  1  one-cycle pulse after an update that changed the latched instruction.

Behaviour:
- Reset values (RST=1):
  - shift stage = CAPTURE_VAL
  - LATCH_JTAG_IR = OPC_IDCODE
  - SELECT = 7'b0000001
  - UNDEF_OPCODE = 0
  - IR_UPDATED = 0
- Per-edge priority: RST > TLR > UPDATE_IR > CAPTURE_IR > SHIFT_IR. The strobes are normally mutually exclusive; if several are asserted together, the highest-priority one acts alone.
- TLR: same effect on the latch, SELECT and UNDEF_OPCODE as RST. The shift stage is unchanged. IR_UPDATED pulses if the latch held a different value before.
- CAPTURE_IR: shift stage <= CAPTURE_VAL.
- SHIFT_IR: shift stage <= {TDI, sr[IR_WIDTH-1:1]}, i.e. LSB first out of IR_TDO, TDI enters at the MSB.
- SHIFT_IR with IR_WIDTH+k clocks: the last IR_WIDTH TDI bits remain. No overflow state exists.
- UPDATE_IR: LATCH_JTAG_IR <= sr. SELECT and UNDEF_OPCODE are decoded from sr and registered on the same edge, so all three change together. Latency is 1 TCK from the UPDATE_IR edge to the outputs.
- IR_UPDATED = 1 on the cycle after an UPDATE_IR or TLR edge whose new latched value differs from the old one. Otherwise 0. Re-updating an identical opcode gives no pulse.
- Decode: exact IR_WIDTH-bit compare against each OPC_*.
  - No match: UNDEF_OPCODE = 1, and SELECT = BYPASS bit if UNDEF_AS_BYPASS=1, else IDCODE bit. The latch still holds the raw undefined value.
- SELECT is always exactly one-hot; it is never all zero, never multi-hot.
- Duplicate OPC_* values are an elaboration error.
- The shift stage is untouched by UPDATE_IR. The latch is untouched by CAPTURE_IR and SHIFT_IR, so the previous instruction stays active while a new one is shifted in.
- RST asserted mid-shift aborts the shift: the next cycle shows reset values, and partial data is lost.
- No strobe asserted: all state holds.

Test Plan:
- Reset: RST=1 for 2 TCK -> LATCH_JTAG_IR=4'h7, SELECT=7'b0000001, UNDEF_OPCODE=0, IR_UPDATED=0, IR_TDO=1 (CAPTURE_VAL bit0).
- Capture/shift/update EXTEST:
  - CAPTURE_IR 1 cycle, then SHIFT_IR 4 cycles with TDI=0,1,0,0 (LSB first) -> IR_TDO sequence 1,0,0,0.
  - Then UPDATE_IR -> next cycle LATCH=4'h2, SELECT=7'b0001000, IR_UPDATED pulse of exactly 1 cycle.
- Undefined opcode 4'hA shifted and updated:
  - UNDEF_AS_BYPASS=1 -> SELECT=7'b0000010, UNDEF_OPCODE=1, LATCH=4'hA.
  - Rerun with UNDEF_AS_BYPASS=0 -> SELECT=7'b0000001.
- Hold and no-repeat:
  - Shift 4'h4 without UPDATE_IR -> SELECT stays on the old instruction.
  - Update -> RUNBIST selected.
  - Update 4'h4 again -> no IR_UPDATED pulse.
- Abort:
  - TLR asserted while LATCH=4'h3 -> LATCH=4'h7, SELECT IDCODE, IR_UPDATED pulse.
  - RST asserted mid-shift (after 2 of 4 bits) -> reset values next cycle.
- IR_WIDTH=8 (OPC_BYPASS=8'hFF), 12 shift cycles of TDI=1 then UPDATE_IR -> LATCH=8'hFF, SELECT BYPASS, UNDEF_OPCODE=0.
